lab2_sweep_ctrl: RTL

- Sequencer that exercises the 4-in/4-out combinational code converter (ports a,b,c,d -> w,x,y,z) on hardware.
- Steps the converter input through a code range and holds each code for a settle window.
- Samples the converter output and compares it against a golden model output fed in parallel.
- Reports error count, first failing code and pass/fail through a start/done handshake, so the board self-checks the converter without a simulator.

---
 rtl/lab2_sweep_ctrl_if.sv | 25 ++
 rtl/lab2_sweep_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/lab2_sweep_ctrl_if.sv
// Handshake and data bundle between the sweep sequencer and its environment.
// The environment (master) owns start/abort and the converter/golden inputs.
interface lab2_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] code_out;
    logic [3:0] conv_in;
    logic [3:0] exp_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic       first_err_valid;
    logic [3:0] first_err_code;

    modport master (
        output start, abort, conv_in, exp_in,
        input  code_out, busy, done, pass, err_cnt, first_err_valid, first_err_code
    );

    modport slave (
        input  start, abort, conv_in, exp_in,
        output code_out, busy, done, pass, err_cnt, first_err_valid, first_err_code
    );
endinterface

// File: rtl/lab2_sweep_ctrl.sv
// On-board self-check sequencer for a 4-in/4-out code converter: sweeps the input
// codes, holds each for a settle window, and compares converter output with a golden model.
module lab2_sweep_ctrl #(
    parameter int unsigned CODE_FIRST = 0,
    parameter int unsigned CODE_LAST  = 9,
    parameter int unsigned SETTLE     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    lab2_sweep_ctrl_if.slave   bus
);

    generate
        if (SETTLE < 1 || CODE_FIRST > CODE_LAST || CODE_LAST > 15) begin : g_bad_params
            $error("lab2_sweep_ctrl: illegal CODE_FIRST/CODE_LAST/SETTLE combination");
        end
    endgenerate

    localparam int unsigned    CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
    localparam logic [3:0]     FIRST_C  = 4'(CODE_FIRST);
    localparam logic [3:0]     LAST_C   = 4'(CODE_LAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    code;
    logic          busy;
    logic          done;
    logic          pass;
    logic [4:0]    err_cnt;
    logic          first_err_valid;
    logic [3:0]    first_err_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            code            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_code  <= '0;
        end else if (state != S_IDLE && bus.abort) begin
            // abort wins over the SAMPLE compare; partial error info is kept
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state           <= S_DRIVE;
                        code            <= FIRST_C;
                        cnt             <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_code  <= '0;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (bus.conv_in != bus.exp_in) begin
                        err_cnt <= err_cnt + 5'd1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_code  <= code;
                        end
                    end
                    // busy drops with the last sample so busy spans exactly (SETTLE+1) per code
                    if (code == LAST_C) begin
                        state <= S_FINISH;
                        busy  <= 1'b0;
                    end else begin
                        code  <= code + 4'd1;
                        cnt   <= '0;
                        state <= S_DRIVE;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    pass  <= (err_cnt == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.code_out        = code;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.pass            = pass;
    assign bus.err_cnt         = err_cnt;
    assign bus.first_err_valid = first_err_valid;
    assign bus.first_err_code  = first_err_code;

endmodule
